// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encodings,
// reset/nop/trap constants and a word-alignment helper.
package if_fetch_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2,
      ST_KILL = 2'd3
   } if_state_t;

   localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INST   = 32'h0000_0000;
   localparam logic [XLEN-1:0] EXC_VECTOR = 32'h8000_0180;

   // Clear the byte-offset bits of an address.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
      return a & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/if_inst_buf.sv
// One-entry instruction holding register.
//   clk, nrst : clock, asynchronous active-low reset
//   load, din : capture din (load wins over clear)
//   clear     : drop the valid flag
//   data      : held word
//   valid     : held word is meaningful
module if_inst_buf
   import if_fetch_pkg::*;
(
   input  logic            clk,
   input  logic            nrst,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] din,
   output logic [XLEN-1:0] data,
   output logic            valid
);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= din;
         valid <= 1'b1;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// holds the instruction under stall and takes redirects.
// Optional macro IF_MISALIGN_EN: misaligned redirect targets trap to
// EXC_VECTOR and expose exc_misalign/exc_badaddr; otherwise targets are
// word-aligned and those ports are absent.
//   clk, nrst                 : clock, asynchronous active-low reset
//   stall                     : IF/ID must not advance
//   redirect, redirect_pc     : taken branch/jump/jr and its target
//   imem_req/addr/ack/rdata   : instruction memory handshake
//   pc_IF, IF_pc4, IF_inst    : presented instruction and its PCs
//   IF_valid                  : presented values are a real fetch
//   exc_misalign, exc_badaddr : trap pulse and offending target (macro only)
module if_fetch
   import if_fetch_pkg::*;
(
   input  logic            clk,
   input  logic            nrst,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] pc_IF,
   output logic [XLEN-1:0] IF_pc4,
   output logic [XLEN-1:0] IF_inst,
   output logic            IF_valid
`ifdef IF_MISALIGN_EN
   ,
   output logic            exc_misalign,
   output logic [XLEN-1:0] exc_badaddr
`endif
);

   if_state_t       state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] kill_target;
   logic [XLEN-1:0] tgt;
   logic            buf_load;
   logic            buf_clear;
   logic [XLEN-1:0] buf_data;
   logic            buf_valid;

   // Effective redirect target.
`ifdef IF_MISALIGN_EN
   logic tgt_trap;
   always_comb begin
      tgt_trap = (redirect_pc[1:0] != 2'b00);
      tgt      = tgt_trap ? EXC_VECTOR : redirect_pc;
   end
`else
   assign tgt = align_word(redirect_pc);
`endif

   assign buf_load  = (state == ST_REQ) && imem_ack && !redirect && stall;
   assign buf_clear = (state == ST_HOLD) && (redirect || !stall);

   if_inst_buf u_buf (
      .clk   (clk),
      .nrst  (nrst),
      .load  (buf_load),
      .clear (buf_clear),
      .din   (imem_rdata),
      .data  (buf_data),
      .valid (buf_valid)
   );

   // Fetch FSM and PC; redirect outranks stall everywhere.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         kill_target <= RESET_PC;
      end else begin
         case (state)
            ST_IDLE: state <= ST_REQ;
            ST_REQ: begin
               if (imem_ack) begin
                  if (redirect)    pc    <= tgt;
                  else if (!stall) pc    <= pc + XLEN'(4);
                  else             state <= ST_HOLD;
               end else if (redirect) begin
                  kill_target <= tgt;
                  state       <= ST_KILL;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  pc    <= tgt;
                  state <= ST_REQ;
               end else if (!stall) begin
                  pc    <= pc + XLEN'(4);
                  state <= ST_REQ;
               end
            end
            ST_KILL: begin
               // Address must stay put until the in-flight request is acked.
               if (imem_ack) begin
                  pc    <= redirect ? tgt : kill_target;
                  state <= ST_REQ;
               end else if (redirect) begin
                  kill_target <= tgt;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef IF_MISALIGN_EN
   // One-cycle trap pulse; offending target held until the next trap.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         exc_misalign <= 1'b0;
         exc_badaddr  <= '0;
      end else begin
         exc_misalign <= redirect && tgt_trap && (state != ST_IDLE);
         if (redirect && tgt_trap && (state != ST_IDLE))
            exc_badaddr <= redirect_pc;
      end
   end
`endif

   // Presentation: live memory data in REQ, buffered word in HOLD.
   always_comb begin
      imem_req = (state == ST_REQ) || (state == ST_KILL);
      IF_valid = 1'b0;
      IF_inst  = NOP_INST;
      case (state)
         ST_REQ: begin
            if (imem_ack && !redirect) begin
               IF_valid = 1'b1;
               IF_inst  = imem_rdata;
            end
         end
         ST_HOLD: begin
            if (buf_valid && !redirect) begin
               IF_valid = 1'b1;
               IF_inst  = buf_data;
            end
         end
         default: ;
      endcase
   end

   assign imem_addr = pc;
   assign pc_IF     = pc;
   assign IF_pc4    = pc + XLEN'(4);

endmodule
